// File: rtl/rv32_decode_pkg.sv
// rv32_decode_pkg: shared constants and types for the RV32I(M) decode stage.
//   ONEHOT_W        width of the one-hot operation vector
//   OP_*            7-bit major opcodes
//   IDX_*           bit positions of each operation inside the one-hot vector
//   decoded_t       registered payload handed to the execute stage
//   stage_state_e   occupancy state of the two-entry skid buffer
package rv32_decode_pkg;

  localparam int unsigned ONEHOT_W = 47;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // R-type ALU
  localparam int unsigned IDX_ADD  = 0;
  localparam int unsigned IDX_SUB  = 1;
  localparam int unsigned IDX_XOR  = 2;
  localparam int unsigned IDX_OR   = 3;
  localparam int unsigned IDX_AND  = 4;
  localparam int unsigned IDX_SLL  = 5;
  localparam int unsigned IDX_SRL  = 6;
  localparam int unsigned IDX_SRA  = 7;
  localparam int unsigned IDX_SLT  = 8;
  localparam int unsigned IDX_SLTU = 9;
  // I-type ALU
  localparam int unsigned IDX_ADDI  = 10;
  localparam int unsigned IDX_XORI  = 11;
  localparam int unsigned IDX_ORI   = 12;
  localparam int unsigned IDX_ANDI  = 13;
  localparam int unsigned IDX_SLLI  = 14;
  localparam int unsigned IDX_SRLI  = 15;
  localparam int unsigned IDX_SRAI  = 16;
  localparam int unsigned IDX_SLTI  = 17;
  localparam int unsigned IDX_SLTIU = 18;
  // Loads and stores
  localparam int unsigned IDX_LB  = 19;
  localparam int unsigned IDX_LH  = 20;
  localparam int unsigned IDX_LW  = 21;
  localparam int unsigned IDX_LBU = 22;
  localparam int unsigned IDX_LHU = 23;
  localparam int unsigned IDX_SB  = 24;
  localparam int unsigned IDX_SH  = 25;
  localparam int unsigned IDX_SW  = 26;
  // Branches
  localparam int unsigned IDX_BEQ  = 27;
  localparam int unsigned IDX_BNE  = 28;
  localparam int unsigned IDX_BLT  = 29;
  localparam int unsigned IDX_BGE  = 30;
  localparam int unsigned IDX_BLTU = 31;
  localparam int unsigned IDX_BGEU = 32;
  // Jumps, upper immediates, system
  localparam int unsigned IDX_JAL    = 33;
  localparam int unsigned IDX_JALR   = 34;
  localparam int unsigned IDX_LUI    = 35;
  localparam int unsigned IDX_AUIPC  = 36;
  localparam int unsigned IDX_ECALL  = 37;
  localparam int unsigned IDX_EBREAK = 38;
  // M extension
  localparam int unsigned IDX_MUL    = 39;
  localparam int unsigned IDX_MULH   = 40;
  localparam int unsigned IDX_MULHSU = 41;
  localparam int unsigned IDX_MULHU  = 42;
  localparam int unsigned IDX_DIV    = 43;
  localparam int unsigned IDX_DIVU   = 44;
  localparam int unsigned IDX_REM    = 45;
  localparam int unsigned IDX_REMU   = 46;

  typedef struct packed {
    logic [ONEHOT_W-1:0] instructions;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [4:0]          rd_addr;
    logic                rd_we;
    logic [31:0]         imm;
    logic [31:0]         pc;
    logic                illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StSkid
  } stage_state_e;

endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side handshakes of the decode stage.
//   in_valid/in_ready/in_instr/in_pc          fetch -> decode
//   out_valid/out_ready/out_*                 decode -> execute
// Modports: slave = the decode stage, master = the surrounding pipeline / bench.
interface instr_decode_stage_if;
  import rv32_decode_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [31:0]         in_pc;

  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] out_instructions;
  logic [4:0]          out_rs1_addr;
  logic [4:0]          out_rs2_addr;
  logic [4:0]          out_rd_addr;
  logic                out_rd_we;
  logic [31:0]         out_imm;
  logic [31:0]         out_pc;
  logic                out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instructions, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rd_we, out_imm, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instructions, out_rs1_addr, out_rs2_addr,
           out_rd_addr, out_rd_we, out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/instr_decode_comb.sv
// instr_decode_comb: purely combinational RV32I(M) decode of one instruction.
//   instr_i  raw 32-bit instruction
//   pc_i     instruction address, forwarded unchanged
//   dec_o    decoded payload (one-hot op, register fields, immediate, illegal flag)
// Build option: define RV32M_EN to decode the M extension; otherwise those
// encodings are reported illegal and no M decode logic exists.
module instr_decode_comb
  import rv32_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decoded_t    dec_o
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [4:0]          rd;
  logic [31:0]         imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic [ONEHOT_W-1:0] onehot;
  logic [31:0]         imm;
  logic                no_wb;
  logic                illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                   1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_sh = {27'b0, instr_i[24:20]};

  always_comb begin
    onehot = '0;
    imm    = '0;
    no_wb  = 1'b0;
    case (opcode)
      OP_LUI: begin
        onehot[IDX_LUI] = 1'b1;
        imm = imm_u;
      end
      OP_AUIPC: begin
        onehot[IDX_AUIPC] = 1'b1;
        imm = imm_u;
      end
      OP_JAL: begin
        onehot[IDX_JAL] = 1'b1;
        imm = imm_j;
      end
      OP_JALR: begin
        imm = imm_i;
        if (funct3 == 3'b000) onehot[IDX_JALR] = 1'b1;
      end
      OP_BRANCH: begin
        imm   = imm_b;
        no_wb = 1'b1;
        case (funct3)
          3'b000:  onehot[IDX_BEQ]  = 1'b1;
          3'b001:  onehot[IDX_BNE]  = 1'b1;
          3'b100:  onehot[IDX_BLT]  = 1'b1;
          3'b101:  onehot[IDX_BGE]  = 1'b1;
          3'b110:  onehot[IDX_BLTU] = 1'b1;
          3'b111:  onehot[IDX_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OP_LOAD: begin
        imm = imm_i;
        case (funct3)
          3'b000:  onehot[IDX_LB]  = 1'b1;
          3'b001:  onehot[IDX_LH]  = 1'b1;
          3'b010:  onehot[IDX_LW]  = 1'b1;
          3'b100:  onehot[IDX_LBU] = 1'b1;
          3'b101:  onehot[IDX_LHU] = 1'b1;
          default: ;
        endcase
      end
      OP_STORE: begin
        imm   = imm_s;
        no_wb = 1'b1;
        case (funct3)
          3'b000:  onehot[IDX_SB] = 1'b1;
          3'b001:  onehot[IDX_SH] = 1'b1;
          3'b010:  onehot[IDX_SW] = 1'b1;
          default: ;
        endcase
      end
      OP_IMM: begin
        imm = imm_i;
        case (funct3)
          3'b000: onehot[IDX_ADDI]  = 1'b1;
          3'b010: onehot[IDX_SLTI]  = 1'b1;
          3'b011: onehot[IDX_SLTIU] = 1'b1;
          3'b100: onehot[IDX_XORI]  = 1'b1;
          3'b110: onehot[IDX_ORI]   = 1'b1;
          3'b111: onehot[IDX_ANDI]  = 1'b1;
          3'b001: begin
            imm = imm_sh;
            if (funct7 == 7'h00) onehot[IDX_SLLI] = 1'b1;
          end
          default: begin  // 3'b101
            imm = imm_sh;
            if (funct7 == 7'h00)      onehot[IDX_SRLI] = 1'b1;
            else if (funct7 == 7'h20) onehot[IDX_SRAI] = 1'b1;
          end
        endcase
      end
      OP_REG: begin
        case (funct7)
          7'h00: begin
            case (funct3)
              3'b000:  onehot[IDX_ADD]  = 1'b1;
              3'b001:  onehot[IDX_SLL]  = 1'b1;
              3'b010:  onehot[IDX_SLT]  = 1'b1;
              3'b011:  onehot[IDX_SLTU] = 1'b1;
              3'b100:  onehot[IDX_XOR]  = 1'b1;
              3'b101:  onehot[IDX_SRL]  = 1'b1;
              3'b110:  onehot[IDX_OR]   = 1'b1;
              default: onehot[IDX_AND]  = 1'b1;
            endcase
          end
          7'h20: begin
            if (funct3 == 3'b000)      onehot[IDX_SUB] = 1'b1;
            else if (funct3 == 3'b101) onehot[IDX_SRA] = 1'b1;
          end
`ifdef RV32M_EN
          7'h01: begin
            case (funct3)
              3'b000:  onehot[IDX_MUL]    = 1'b1;
              3'b001:  onehot[IDX_MULH]   = 1'b1;
              3'b010:  onehot[IDX_MULHSU] = 1'b1;
              3'b011:  onehot[IDX_MULHU]  = 1'b1;
              3'b100:  onehot[IDX_DIV]    = 1'b1;
              3'b101:  onehot[IDX_DIVU]   = 1'b1;
              3'b110:  onehot[IDX_REM]    = 1'b1;
              default: onehot[IDX_REMU]   = 1'b1;
            endcase
          end
`endif
          default: ;
        endcase
      end
      OP_SYSTEM: begin
        imm   = imm_i;
        no_wb = 1'b1;
        // Only the two exact encodings are accepted; CSR ops are not supported.
        if (instr_i[31:7] == 25'h0000000)      onehot[IDX_ECALL]  = 1'b1;
        else if (instr_i[31:7] == 25'h0002000) onehot[IDX_EBREAK] = 1'b1;
      end
      default: ;
    endcase
    // Compressed / non-32-bit encodings never decode, whatever the opcode table says.
    if (instr_i[1:0] != 2'b11) onehot = '0;
  end

  // Illegal is simply "no operation matched", so the vector and flag can never disagree.
  assign illegal = ~|onehot;

  assign dec_o.instructions = onehot;
  assign dec_o.rs1_addr     = instr_i[19:15];
  assign dec_o.rs2_addr     = instr_i[24:20];
  assign dec_o.rd_addr      = rd;
  assign dec_o.rd_we        = !illegal && !no_wb && (rd != 5'd0);
  assign dec_o.imm          = imm;
  assign dec_o.pc           = pc_i;
  assign dec_o.illegal      = illegal;

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode stage between fetch and execute.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous discard of both buffered entries (highest priority)
//   bus         instr_decode_stage_if.slave: fetch handshake in, decoded payload out
// Decoding happens before the register; a main register (M) and a skid register (S)
// let in_ready come straight from a flop, so execute backpressure never reaches fetch
// combinationally. Build option: RV32M_EN enables M-extension decode.
module instr_decode_stage
  import rv32_decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  instr_decode_stage_if.slave   bus
);

  decoded_t     dec;
  decoded_t     m_q, m_d;
  decoded_t     s_q, s_d;
  stage_state_e state_q, state_d;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         accept;
  logic         fire;

  instr_decode_comb u_decode (
    .instr_i (bus.in_instr),
    .pc_i    (bus.in_pc),
    .dec_o   (dec)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign fire   = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          m_d     = dec;
          state_d = StFull;
        end
      end
      StFull: begin
        if (accept && fire) begin
          m_d = dec;
        end else if (fire) begin
          state_d = StEmpty;
        end else if (accept) begin
          s_d     = dec;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (fire) begin
          m_d     = s_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase
    // M may still be overwritten on a flush cycle, but out_valid drops so it is never seen.
    if (flush) state_d = StEmpty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= (state_d != StSkid);
      out_valid_q <= (state_d != StEmpty);
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.out_instructions = m_q.instructions;
  assign bus.out_rs1_addr     = m_q.rs1_addr;
  assign bus.out_rs2_addr     = m_q.rs2_addr;
  assign bus.out_rd_addr      = m_q.rd_addr;
  assign bus.out_rd_we        = m_q.rd_we;
  assign bus.out_imm          = m_q.imm;
  assign bus.out_pc           = m_q.pc;
  assign bus.out_illegal      = m_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: self-checking bench for instr_decode_stage.
// A pattern-table reference decoder plus a queue scoreboard predicts every payload.
module tb_instr_decode_stage;
  import rv32_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  instr_decode_stage_if bus ();

  instr_decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [46:0] oh;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         cf3;
    bit         cf7;
    int         idx;
    byte        fmt;
  } pat_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  pat_t pats[$];
  vec_t vecs[$];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  bit          hold_pending = 0;
  logic [46:0] hold_oh;
  logic [31:0] hold_pc;
  logic [31:0] hold_imm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input bit cf3, input bit cf7, input int idx, input byte fmt);
    pat_t p;
    p.op = op; p.f3 = f3; p.f7 = f7; p.cf3 = cf3; p.cf7 = cf7; p.idx = idx; p.fmt = fmt;
    pats.push_back(p);
  endfunction

  // Reference decoder: first matching pattern in the table wins; no match means illegal.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    int          idx = -1;
    byte         fmt = "R";
    logic [31:0] sx;
    sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.pc = pc; e.imm = '0; e.oh = '0;
    if (w == 32'h0000_0073) begin
      idx = 37; fmt = "I";
    end else if (w == 32'h0010_0073) begin
      idx = 38; fmt = "I";
    end else begin
      foreach (pats[k]) begin
        if (idx < 0 && w[6:0] == pats[k].op && (!pats[k].cf3 || w[14:12] == pats[k].f3) &&
            (!pats[k].cf7 || w[31:25] == pats[k].f7)) begin
          idx = pats[k].idx;
          fmt = pats[k].fmt;
        end
      end
    end
    case (fmt)
      "I": e.imm = (sx << 12) | 32'(w[31:20]);
      "H": e.imm = 32'(w[24:20]);
      "S": e.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
      "B": e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      "J": e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) |
                   (32'(w[30:21]) << 1);
      "U": e.imm = w & 32'hFFFF_F000;
      default: e.imm = 32'h0;
    endcase
    e.ill = (idx < 0);
    if (!e.ill) e.oh = 47'd1 << idx;
    e.we = !e.ill && (e.rd != 5'd0) && !(fmt == "S" || fmt == "B" || idx == 37 || idx == 38);
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".instructions"}, 64'(bus.out_instructions), 64'(e.oh));
    chk({tag, ".rs1"}, 64'(bus.out_rs1_addr), 64'(e.rs1));
    chk({tag, ".rs2"}, 64'(bus.out_rs2_addr), 64'(e.rs2));
    chk({tag, ".rd"}, 64'(bus.out_rd_addr), 64'(e.rd));
    chk({tag, ".rd_we"}, 64'(bus.out_rd_we), 64'(e.we));
    chk({tag, ".pc"}, 64'(bus.out_pc), 64'(e.pc));
    chk({tag, ".illegal"}, 64'(bus.out_illegal), 64'(e.ill));
    if (!e.ill) chk({tag, ".imm"}, 64'(bus.out_imm), 64'(e.imm));
  endtask

  // One clock: check occupancy and held outputs, score the handshakes, advance to edge+1.
  task automatic tick();
    bit   acc, fire;
    exp_t e;
    if (hold_pending) begin
      chk("hold.instructions", 64'(bus.out_instructions), 64'(hold_oh));
      chk("hold.pc", 64'(bus.out_pc), 64'(hold_pc));
      chk("hold.imm", 64'(bus.out_imm), 64'(hold_imm));
    end
    chk("out_valid", 64'(bus.out_valid), 64'(sbq.size() > 0));
    chk("in_ready", 64'(bus.in_ready), 64'(sbq.size() < 2));
    acc  = bus.in_valid && bus.in_ready;
    fire = bus.out_valid && bus.out_ready;
    if (fire) begin
      if (sbq.size() == 0) chk("spurious_output", 64'(1), 64'(0));
      else begin
        e = sbq.pop_front();
        cmp_out("sb", e);
      end
    end
    if (flush) sbq.delete();
    else if (acc) sbq.push_back(model(bus.in_instr, bus.in_pc));
    hold_pending = bus.out_valid && !bus.out_ready && !flush;
    hold_oh  = bus.out_instructions;
    hold_pc  = bus.out_pc;
    hold_imm = bus.out_imm;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [31:0] instr, input logic [46:0] oh,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic we, input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = instr; v.e.oh = oh; v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.rd = rd;
    v.e.we = we; v.e.imm = imm; v.e.ill = ill; v.e.pc = '0;
    return v;
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 12)
      0: w[6:0] = OP_LUI;
      1: w[6:0] = OP_AUIPC;
      2: w[6:0] = OP_JAL;
      3: w[6:0] = OP_JALR;
      4: w[6:0] = OP_BRANCH;
      5: w[6:0] = OP_LOAD;
      6: w[6:0] = OP_STORE;
      7: w[6:0] = OP_IMM;
      8: w[6:0] = OP_REG;
      9: w = ($urandom % 2 == 0) ? 32'h0000_0073 : 32'h0010_0073;
      10: w[6:0] = 7'h0F;
      default: ;
    endcase
    if (w[6:0] == OP_IMM || w[6:0] == OP_REG) begin
      case ($urandom % 4)
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    // Reference pattern table.
    add(7'h33, 3'd0, 7'h00, 1, 1, 0, "R");  add(7'h33, 3'd0, 7'h20, 1, 1, 1, "R");
    add(7'h33, 3'd4, 7'h00, 1, 1, 2, "R");  add(7'h33, 3'd6, 7'h00, 1, 1, 3, "R");
    add(7'h33, 3'd7, 7'h00, 1, 1, 4, "R");  add(7'h33, 3'd1, 7'h00, 1, 1, 5, "R");
    add(7'h33, 3'd5, 7'h00, 1, 1, 6, "R");  add(7'h33, 3'd5, 7'h20, 1, 1, 7, "R");
    add(7'h33, 3'd2, 7'h00, 1, 1, 8, "R");  add(7'h33, 3'd3, 7'h00, 1, 1, 9, "R");
    add(7'h13, 3'd0, 7'h00, 1, 0, 10, "I"); add(7'h13, 3'd4, 7'h00, 1, 0, 11, "I");
    add(7'h13, 3'd6, 7'h00, 1, 0, 12, "I"); add(7'h13, 3'd7, 7'h00, 1, 0, 13, "I");
    add(7'h13, 3'd1, 7'h00, 1, 1, 14, "H"); add(7'h13, 3'd5, 7'h00, 1, 1, 15, "H");
    add(7'h13, 3'd5, 7'h20, 1, 1, 16, "H"); add(7'h13, 3'd2, 7'h00, 1, 0, 17, "I");
    add(7'h13, 3'd3, 7'h00, 1, 0, 18, "I");
    add(7'h03, 3'd0, 7'h00, 1, 0, 19, "I"); add(7'h03, 3'd1, 7'h00, 1, 0, 20, "I");
    add(7'h03, 3'd2, 7'h00, 1, 0, 21, "I"); add(7'h03, 3'd4, 7'h00, 1, 0, 22, "I");
    add(7'h03, 3'd5, 7'h00, 1, 0, 23, "I");
    add(7'h23, 3'd0, 7'h00, 1, 0, 24, "S"); add(7'h23, 3'd1, 7'h00, 1, 0, 25, "S");
    add(7'h23, 3'd2, 7'h00, 1, 0, 26, "S");
    add(7'h63, 3'd0, 7'h00, 1, 0, 27, "B"); add(7'h63, 3'd1, 7'h00, 1, 0, 28, "B");
    add(7'h63, 3'd4, 7'h00, 1, 0, 29, "B"); add(7'h63, 3'd5, 7'h00, 1, 0, 30, "B");
    add(7'h63, 3'd6, 7'h00, 1, 0, 31, "B"); add(7'h63, 3'd7, 7'h00, 1, 0, 32, "B");
    add(7'h6F, 3'd0, 7'h00, 0, 0, 33, "J"); add(7'h67, 3'd0, 7'h00, 1, 0, 34, "I");
    add(7'h37, 3'd0, 7'h00, 0, 0, 35, "U"); add(7'h17, 3'd0, 7'h00, 0, 0, 36, "U");
`ifdef RV32M_EN
    for (int f = 0; f < 8; f++) add(7'h33, 3'(f), 7'h01, 1, 1, 39 + f, "R");
`endif

    // Directed vectors: instr, one-hot, rs1, rs2, rd, rd_we, imm, illegal.
    vecs.push_back(mkv(32'h0050_0093, 47'h400, 0, 5, 1, 1, 32'd5, 0));
    vecs.push_back(mkv(32'h4020_8133, 47'h2, 1, 2, 2, 1, 32'd0, 0));
`ifdef RV32M_EN
    vecs.push_back(mkv(32'h0220_81B3, 47'd1 << 39, 1, 2, 3, 1, 32'd0, 0));
`else
    vecs.push_back(mkv(32'h0220_81B3, 47'h0, 1, 2, 3, 0, 32'd0, 1));
`endif
    vecs.push_back(mkv(32'hFFFF_FFFF, 47'h0, 31, 31, 31, 0, 32'd0, 1));
    vecs.push_back(mkv(32'h0000_0000, 47'h0, 0, 0, 0, 0, 32'd0, 1));
    vecs.push_back(mkv(32'h4033_5293, 47'd1 << 16, 6, 3, 5, 1, 32'd3, 0));
    vecs.push_back(mkv(32'h0200_9093, 47'h0, 1, 0, 1, 0, 32'd0, 1));
    vecs.push_back(mkv(32'hFE20_AE23, 47'd1 << 26, 1, 2, 28, 0, 32'hFFFF_FFFC, 0));
    vecs.push_back(mkv(32'hFE00_0CE3, 47'd1 << 27, 0, 0, 25, 0, 32'hFFFF_FFF8, 0));
    vecs.push_back(mkv(32'h1234_53B7, 47'd1 << 35, 8, 3, 7, 1, 32'h1234_5000, 0));
    vecs.push_back(mkv(32'h0000_0073, 47'd1 << 37, 0, 0, 0, 0, 32'd0, 0));
    vecs.push_back(mkv(32'h0010_0073, 47'd1 << 38, 0, 1, 0, 0, 32'd1, 0));
    vecs.push_back(mkv(32'h0100_00EF, 47'd1 << 33, 0, 16, 1, 1, 32'd16, 0));
    vecs.push_back(mkv(32'h0010_0013, 47'h400, 0, 1, 0, 0, 32'd1, 0));
    vecs.push_back(mkv(32'h0050_0091, 47'h0, 0, 5, 1, 0, 32'd0, 1));

    bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset.in_ready", 64'(bus.in_ready), 64'(1));
    chk("reset.instructions", 64'(bus.out_instructions), 64'(0));
    chk("reset.illegal", 64'(bus.out_illegal), 64'(0));
    chk("reset.pc", 64'(bus.out_pc), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Table-driven vectors: one-cycle latency and decoded fields.
    foreach (vecs[i]) begin
      exp_t e;
      e = vecs[i].e;
      e.pc = 32'h1000 + 32'(i) * 4;
      bus.in_instr = vecs[i].instr; bus.in_pc = e.pc; bus.in_valid = 1; bus.out_ready = 1;
      tick();
      bus.in_valid = 0;
      chk($sformatf("vec%0d.out_valid", i), 64'(bus.out_valid), 64'(1));
      cmp_out($sformatf("vec%0d", i), e);
      tick();
    end

    // Full throughput: back-to-back accepts with out_ready held high.
    bus.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1; bus.in_instr = gen(); bus.in_pc = 32'h2000 + 32'(i) * 4;
      tick();
      chk("thru.in_ready", 64'(bus.in_ready), 64'(1));
      chk("thru.pc", 64'(bus.out_pc), 64'(32'h2000 + 32'(i) * 4));
    end
    bus.in_valid = 0;
    tick();

    // Backpressure: A, B accepted, C stalls, then drains A, B, C with no gaps.
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_instr = 32'h0050_0093; bus.in_pc = 32'hA0; tick();
    bus.in_instr = 32'h4020_8133; bus.in_pc = 32'hB0; tick();
    chk("bp.in_ready_low", 64'(bus.in_ready), 64'(0));
    bus.in_instr = 32'h0010_0073; bus.in_pc = 32'hC0;
    tick(); tick();
    chk("bp.held_pc", 64'(bus.out_pc), 64'(32'hA0));
    bus.out_ready = 1;
    chk("bp.first", 64'(bus.out_pc), 64'(32'hA0));
    tick();
    chk("bp.second", 64'(bus.out_pc), 64'(32'hB0));
    tick();
    bus.in_valid = 0;
    chk("bp.third_valid", 64'(bus.out_valid), 64'(1));
    chk("bp.third", 64'(bus.out_pc), 64'(32'hC0));
    tick();
    chk("bp.empty", 64'(bus.out_valid), 64'(0));

    // Flush while in SKID, with a same-cycle input that must be dropped.
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_instr = gen(); bus.in_pc = 32'hD0; tick();
    bus.in_instr = gen(); bus.in_pc = 32'hD4; tick();
    flush = 1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'hD8;
    tick();
    flush = 0; bus.in_valid = 0;
    chk("flush.out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush.in_ready", 64'(bus.in_ready), 64'(1));
    bus.out_ready = 1;
    repeat (3) tick();

    // Asynchronous reset mid-stream.
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_instr = gen(); bus.in_pc = 32'hE0; tick();
    bus.in_instr = gen(); bus.in_pc = 32'hE4; tick();
    #2;
    rst_n = 0;
    #1;
    chk("arst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst.in_ready", 64'(bus.in_ready), 64'(1));
    chk("arst.instructions", 64'(bus.out_instructions), 64'(0));
    sbq.delete();
    hold_pending = 0;
    bus.in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 1;
    repeat (3) tick();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      flush         = ($urandom % 40) == 0;
      bus.in_instr  = gen();
      bus.in_pc     = $urandom;
      tick();
    end

    // Drain and confirm nothing was lost or duplicated.
    flush = 0; bus.in_valid = 0; bus.out_ready = 1;
    repeat (4) tick();
    chk("drain.empty", 64'(sbq.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I(M) decode stage that turns a raw 32-bit instruction into the 47-bit one-hot `instructions` vector, operand addresses and immediate consumed by the execute-stage ALU. It sits between fetch and execute, with valid/ready handshakes on both sides. A two-entry skid buffer keeps `in_ready` a registered signal, so backpressure from execute never combinationally reaches fetch.

## Interface
- `ONEHOT_W`, 47: width of the one-hot operation vector. The fixed bit map is defined in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous discard of all buffered entries.
- `in_valid` in 1: `in_instr`/`in_pc` valid.
- `in_ready` out 1: stage can accept.
- `in_instr` in 32: raw instruction.
- `in_pc` in 32: instruction address.
- `out_valid` out 1: decoded payload valid.
- `out_ready` in 1: execute accepts payload.
- `out_instructions` out 47: one-hot operation, or all-zero when illegal.
- `out_rs1_addr`, `out_rs2_addr`, `out_rd_addr` out 5 each: register addresses.
- `out_rd_we` out 1: destination write enable.
- `out_imm` out 32: decoded immediate.
- `out_pc` out 32: forwarded PC.
- `out_illegal` out 1: encoding not recognised.

## Operation
- **Bit map:**
  - 0–9: add, sub, xor, or, and, sll, srl, sra, slt, sltu
  - 10–18: addi, xori, ori, andi, slli, srli, srai, slti, sltiu
  - 19–23: lb, lh, lw, lbu, lhu
  - 24–26: sb, sh, sw
  - 27–32: beq, bne, blt, bge, bltu, bgeu
  - 33–38: jal, jalr, lui, auipc, ecall, ebreak
  - 39–46: mul, mulh, mulhsu, mulhu, div, divu, rem, remu
- **Valid vector:** exactly one bit set for a legal instruction.
- **Immediates:**
  - I/S/B/J formats are sign-extended to 32 bits. B and J immediates carry bit 0 = 0.
  - U format is `{instr[31:12], 12'b0}`.
  - slli/srli/srai produce `imm = {27'b0, shamt}`.
  - R-type produces `imm = 0`.
- **Illegal:** any of the following sets `out_illegal=1`, `out_instructions=0` and `out_rd_we=0`:
  - unknown opcode, funct3 or funct7;
  - shift-immediate with `instr[31:25]` not 0x00, or not 0x20 for srai;
  - `instr[1:0] != 2'b11`.
- **Write enable:** `out_rd_we=0` for stores, branches, ecall, ebreak and illegal instructions, and whenever rd=x0.
- **Field pass-through:** `rs1`, `rs2` and `rd` fields are passed through raw regardless of format.
- **States** (main register M, skid register S):
  - EMPTY: `out_valid=0`. An accepted input goes to M, then FULL.
  - FULL: `out_valid=1`. Input and output in the same cycle: M is replaced, stay FULL. Output only: go to EMPTY. Input only (`out_ready=0`): entry goes to S, then SKID.
  - SKID: `in_ready=0`. On `out_ready`, S moves to M, then FULL.
- **Handshake and ordering:**
  - `in_ready = (state != SKID)`.
  - Strict in-order delivery, with no drop and no duplication.
  - While `out_valid=1 && out_ready=0`, every output is held stable.
- **Flush:** has highest priority. Next state is EMPTY and any same-cycle input is dropped.

## Timing
- **Reset:** all outputs reset to 0 (`out_valid=0`, `out_instructions=0`, `out_illegal=0`), except `in_ready=1`. Reset is asynchronous on assertion and synchronous on release. Asserting reset mid-stream discards both entries immediately.
- **Latency:** exactly 1 cycle from accept to `out_valid` at full throughput, with 1 instruction per cycle sustained when `out_ready=1`.
- **Registered outputs:** `in_ready` is registered. All `out_*` signals are registered, with no combinational path from input to output.
- **Decode timing:** decode logic is evaluated on the `in_*` side before the register.

## Configuration
- `RV32M_EN`:
  - Defined: opcode 0x33 with funct7=0x01 decodes to bits 39–46.
  - Undefined: those encodings are illegal, bits 39–46 are never set, and the M decode logic is absent.

## Structure
- **Package `rv32_decode_pkg`** holds:
  - opcode constants (`OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`, `OP_SYSTEM`);
  - one-hot bit-index constants for all 47 operations;
  - `ONEHOT_W`;
  - a packed struct typedef for the decoded payload.
- **Sub-module `instr_decode_comb`:** purely combinational decode of instruction to payload struct.
- **`instr_decode_stage`:** owns the skid buffer and the state machine.

## Test plan
- `0x00500093` (addi x1,x0,5) → one cycle later: `out_instructions=0x400`, rd=1, rs1=0, `imm=5`, `rd_we=1`.
- `0x40208133` (sub x2,x1,x2) → `out_instructions=0x2`, rs1=1, rs2=2, rd=2, `imm=0`.
- `0x022081B3` (mul x3,x1,x2):
  - with `RV32M_EN`: bit 39 set, `illegal=0`;
  - without it: `out_instructions=0`, `illegal=1`, `rd_we=0`.
- `0xFFFFFFFF` and `0x00000000` → `illegal=1`, vector 0.
- Backpressure: stream A, B, C with `out_ready=0` for 3 cycles → `in_ready` falls after B is accepted, and C waits. After release, the output sequence is A, B, C with no gaps.
- `flush` in SKID state, and `rst_n` pulled low mid-stream → `out_valid=0` (immediately for reset, next cycle for flush), `in_ready=1`, and nothing stale appears afterwards.
